// File: rtl/rgbd_frame_streamer.sv
// Raster RGB-D frame streamer: fetches one frame from an in-order, variable-latency read port
// and emits it with frame_start/frame_end flags. Optional depth gating: RGBD_STREAM_DEPTH_GATE_EN.
module rgbd_frame_streamer #(
  parameter int unsigned ADDR_BW       = 20,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned H_SIZE_BW     = 12,
  parameter int unsigned V_SIZE_BW     = 12,
  parameter int unsigned DATA_RGB_BW   = 24,
  parameter int unsigned DATA_DEPTH_BW = 16,
  parameter int unsigned MIN_DEPTH     = 100,
  parameter int unsigned MAX_DEPTH     = 4000
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst_n,
  input  logic                                   i_start,
  input  logic [H_SIZE_BW-1:0]                   r_hsize,
  input  logic [V_SIZE_BW-1:0]                   r_vsize,
  input  logic [ADDR_BW-1:0]                     r_base_addr,
  output logic                                   o_rd_req,
  output logic [ADDR_BW-1:0]                     o_rd_addr,
  input  logic                                   i_rd_ready,
  input  logic                                   i_rd_valid,
  input  logic [DATA_RGB_BW+DATA_DEPTH_BW-1:0]   i_rd_data,
  output logic                                   o_frame_start,
  output logic                                   o_frame_end,
  output logic                                   o_valid,
  output logic [DATA_RGB_BW-1:0]                 o_data0,
  output logic [DATA_DEPTH_BW-1:0]               o_depth0,
  output logic                                   o_busy
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned DW = DATA_RGB_BW + DATA_DEPTH_BW;
`ifdef RGBD_STREAM_DEPTH_GATE_EN
  localparam bit GATE_EN = 1'b1;
`else
  localparam bit GATE_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_t;

  state_t                   r_state;
  logic [H_SIZE_BW-1:0]     r_hs, r_req_x, r_out_x;
  logic [V_SIZE_BW-1:0]     r_vs, r_req_y, r_out_y;
  logic [ADDR_BW-1:0]       r_rd_addr;
  logic [CW-1:0]            r_infl, r_cnt;
  logic [PW-1:0]            r_wp, r_rp;
  logic [DW-1:0]            r_mem [FIFO_DEPTH];
  logic                     r_valid, r_fs, r_fe;
  logic [DATA_RGB_BW-1:0]   r_rgb;
  logic [DATA_DEPTH_BW-1:0] r_dep;

  logic [CW-1:0]            w_credit;
  logic                     w_req, w_acc, w_req_xl, w_req_yl;
  logic                     w_rd, w_byp, w_wr, w_pop, w_out_xl, w_out_yl;
  logic [DW-1:0]            w_pix;
  logic [DATA_DEPTH_BW-1:0] w_pix_dep, w_dep;

  assign w_credit = CW'(FIFO_DEPTH) - r_cnt - r_infl;
  assign w_req    = (r_state == S_REQ) && (w_credit != '0);
  assign w_acc    = w_req && i_rd_ready;
  assign w_req_xl = (r_req_x == r_hs - H_SIZE_BW'(1));
  assign w_req_yl = (r_req_y == r_vs - V_SIZE_BW'(1));

  // A return arriving into an empty buffer bypasses storage so it reaches the outputs next cycle.
  assign w_rd      = (r_cnt != '0);
  assign w_byp     = i_rd_valid && !w_rd;
  assign w_wr      = i_rd_valid && w_rd;
  assign w_pop     = w_rd || w_byp;
  assign w_pix     = w_rd ? r_mem[r_rp] : i_rd_data;
  assign w_pix_dep = w_pix[DATA_DEPTH_BW-1:0];
  assign w_out_xl  = (r_out_x == r_hs - H_SIZE_BW'(1));
  assign w_out_yl  = (r_out_y == r_vs - V_SIZE_BW'(1));

  always_comb begin
    w_dep = w_pix_dep;
    if (GATE_EN && ((w_pix_dep <= DATA_DEPTH_BW'(MIN_DEPTH)) ||
                    (w_pix_dep >= DATA_DEPTH_BW'(MAX_DEPTH))))
      w_dep = '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_hs      <= '0;
      r_vs      <= '0;
      r_rd_addr <= '0;
      r_req_x   <= '0;
      r_req_y   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_hs      <= r_hsize;
          r_vs      <= r_vsize;
          r_rd_addr <= r_base_addr;
          r_req_x   <= '0;
          r_req_y   <= '0;
          r_state   <= S_REQ;
        end
        S_REQ: if (w_acc) begin
          r_rd_addr <= r_rd_addr + ADDR_BW'(1);
          r_req_x   <= w_req_xl ? '0 : r_req_x + H_SIZE_BW'(1);
          if (w_req_xl) r_req_y <= w_req_yl ? '0 : r_req_y + V_SIZE_BW'(1);
          if (w_req_xl && w_req_yl) r_state <= S_DRAIN;
        end
        S_DRAIN: if (r_fe) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_infl <= '0;
      r_cnt  <= '0;
      r_wp   <= '0;
      r_rp   <= '0;
    end else begin
      case ({w_acc, i_rd_valid})
        2'b10:   r_infl <= r_infl + CW'(1);
        2'b01:   r_infl <= r_infl - CW'(1);
        default: r_infl <= r_infl;
      endcase
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (w_wr) r_wp <= r_wp + PW'(1);
      if (w_rd) r_rp <= r_rp + PW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wp] <= i_rd_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_x <= '0;
      r_out_y <= '0;
      r_valid <= 1'b0;
      r_fs    <= 1'b0;
      r_fe    <= 1'b0;
      r_rgb   <= '0;
      r_dep   <= '0;
    end else begin
      r_valid <= w_pop;
      r_fs    <= w_pop && (r_out_x == '0) && (r_out_y == '0);
      r_fe    <= w_pop && w_out_xl && w_out_yl;
      if (w_pop) begin
        r_rgb   <= w_pix[DW-1:DATA_DEPTH_BW];
        r_dep   <= w_dep;
        r_out_x <= w_out_xl ? '0 : r_out_x + H_SIZE_BW'(1);
        if (w_out_xl) r_out_y <= w_out_yl ? '0 : r_out_y + V_SIZE_BW'(1);
      end
    end
  end

  assign o_rd_req      = w_req;
  assign o_rd_addr     = r_rd_addr;
  assign o_valid       = r_valid;
  assign o_frame_start = r_fs;
  assign o_frame_end   = r_fe;
  assign o_data0       = r_rgb;
  assign o_depth0      = r_dep;
  assign o_busy        = (r_state != S_IDLE);
endmodule

// File: tb/tb_rgbd_frame_streamer.sv
// Scoreboard bench for rgbd_frame_streamer: a memory model answers read requests, expected
// addresses and pixels are queued at frame start and checked by independent monitor processes.
module tb_rgbd_frame_streamer;
  localparam int unsigned ADDR_BW = 20, FIFO_DEPTH = 8, HB = 12, VB = 12, RB = 24, DB = 16;
  localparam int unsigned MIN_D = 100, MAX_D = 4000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               i_rst_n, i_start, o_rd_req, i_rd_ready, i_rd_valid;
  logic [HB-1:0]      r_hsize;
  logic [VB-1:0]      r_vsize;
  logic [ADDR_BW-1:0] r_base_addr, o_rd_addr;
  logic [RB+DB-1:0]   i_rd_data;
  logic               o_frame_start, o_frame_end, o_valid, o_busy;
  logic [RB-1:0]      o_data0;
  logic [DB-1:0]      o_depth0;

  rgbd_frame_streamer #(
    .ADDR_BW(ADDR_BW), .FIFO_DEPTH(FIFO_DEPTH), .H_SIZE_BW(HB), .V_SIZE_BW(VB),
    .DATA_RGB_BW(RB), .DATA_DEPTH_BW(DB), .MIN_DEPTH(MIN_D), .MAX_DEPTH(MAX_D)
  ) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .r_hsize(r_hsize), .r_vsize(r_vsize), .r_base_addr(r_base_addr),
    .o_rd_req(o_rd_req), .o_rd_addr(o_rd_addr), .i_rd_ready(i_rd_ready),
    .i_rd_valid(i_rd_valid), .i_rd_data(i_rd_data),
    .o_frame_start(o_frame_start), .o_frame_end(o_frame_end), .o_valid(o_valid),
    .o_data0(o_data0), .o_depth0(o_depth0), .o_busy(o_busy)
  );

  int n_vec = 0, n_err = 0, cyc = 0;
  always @(posedge clk) cyc++;

  logic [RB+DB+1:0]   exp_q[$];
  logic [ADDR_BW-1:0] addr_q[$];

  int                 lat = 1, stall_en = 0, ovr_en = 0, max_occ = 0;
  int                 pix_seen = 0, fs_cyc = 0, fe_cyc = 0;
  logic [ADDR_BW-1:0] stall_exp = '0, ovr_base = '0;
  logic [DB-1:0]      dtab[3];
  logic [DB-1:0]      exp_dtab[3];

  function automatic logic [RB+DB-1:0] mem_word(input logic [ADDR_BW-1:0] a);
    logic [DB-1:0] d;
    d = 16'd1000 + {6'd0, a[9:0]};
    return {a[11:0], ~a[11:0], d};
  endfunction

  // Memory model: in-order returns after 'lat' cycles, optional ready stall on the 3rd request.
  initial begin
    int                 due_q[$];
    logic [RB+DB-1:0]   dat_q[$];
    logic [RB+DB-1:0]   w;
    logic [ADDR_BW-1:0] ea, off;
    int acc_tot, val_tot, k, stall_cnt;
    acc_tot = 0; val_tot = 0; k = 0; stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (!i_rst_n) begin
        due_q.delete(); dat_q.delete();
        acc_tot = 0; val_tot = 0; k = 0; stall_cnt = 0;
        i_rd_valid = 1'b0; i_rd_data = '0; i_rd_ready = 1'b1;
        continue;
      end
      if (o_valid) val_tot++;
      if (acc_tot - val_tot > max_occ) max_occ = acc_tot - val_tot;
      if (!o_busy) begin k = 0; stall_cnt = 0; end
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        i_rd_valid = 1'b1;
        i_rd_data  = dat_q.pop_front();
        void'(due_q.pop_front());
      end else begin
        i_rd_valid = 1'b0;
        i_rd_data  = '0;
      end
      i_rd_ready = 1'b1;
      if (o_rd_req && stall_en != 0 && k == 2 && stall_cnt < 5) begin
        i_rd_ready = 1'b0;
        stall_cnt++;
        n_vec++;
        if (o_rd_addr !== stall_exp) begin
          n_err++;
          $display("FAIL stall_hold: addr got %h expected %h", o_rd_addr, stall_exp);
        end
      end
      if (o_rd_req && i_rd_ready) begin
        n_vec++;
        if (addr_q.size() == 0) begin
          n_err++;
          $display("FAIL rd_addr: unexpected request addr %h, expected none", o_rd_addr);
        end else begin
          ea = addr_q.pop_front();
          if (o_rd_addr !== ea) begin
            n_err++;
            $display("FAIL rd_addr: got %h expected %h", o_rd_addr, ea);
          end
        end
        w   = mem_word(o_rd_addr);
        off = o_rd_addr - ovr_base;
        if (ovr_en != 0 && off < 3) w[DB-1:0] = dtab[off];
        dat_q.push_back(w);
        due_q.push_back(cyc + lat);
        acc_tot++;
        k++;
      end
    end
  end

  // Output monitor: pops the pixel scoreboard on every o_valid, checks busy after frame_end.
  initial begin
    logic [RB+DB+1:0] e, a;
    bit chk_busy;
    chk_busy = 0;
    forever begin
      @(negedge clk);
      if (chk_busy) begin
        chk_busy = 0;
        n_vec++;
        if (o_busy !== 1'b0) begin
          n_err++;
          $display("FAIL busy_fall: o_busy got %b expected 0", o_busy);
        end
      end
      if (o_valid) begin
        pix_seen++;
        a = {o_data0, o_depth0, o_frame_start, o_frame_end};
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL pixel: unexpected pixel %h, expected none", a);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            n_err++;
            $display("FAIL pixel: {rgb,depth,fs,fe} got %h expected %h", a, e);
          end
        end
        if (o_frame_start) fs_cyc = cyc;
        if (o_frame_end) begin fe_cyc = cyc; chk_busy = 1; end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  int t0 = 0;

  task automatic start_frame(input int hs, input int vs, input logic [ADDR_BW-1:0] base, input int l);
    logic [RB+DB-1:0]   w;
    logic [ADDR_BW-1:0] a;
    lat = l;
    for (int i = 0; i < hs * vs; i++) begin
      a = base + ADDR_BW'(i);
      w = mem_word(a);
      if (ovr_en != 0 && i < 3) w[DB-1:0] = exp_dtab[i];
      exp_q.push_back({w, i == 0, i == hs * vs - 1});
      addr_q.push_back(a);
    end
    @(negedge clk);
    i_start = 1'b1; r_hsize = HB'(hs); r_vsize = VB'(vs); r_base_addr = base;
    t0 = cyc;
    @(negedge clk);
    i_start = 1'b0; r_hsize = 1; r_vsize = 1; r_base_addr = '0;
    check("start_resp {busy,req,addr}", {42'd0, o_busy, o_rd_req, o_rd_addr}, {42'd0, 1'b1, 1'b1, base});
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && addr_q.size() == 0 && !o_busy) break;
    end
    n_vec++;
    if (i == 3000) begin
      n_err++;
      $display("FAIL frame_timeout: %0d pixels still pending, expected 0", exp_q.size());
      exp_q.delete(); addr_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int p0, i;
    i_rst_n = 1'b0; i_start = 1'b0; r_hsize = '0; r_vsize = '0; r_base_addr = '0;
    i_rd_ready = 1'b1; i_rd_valid = 1'b0; i_rd_data = '0;
    dtab[0] = DB'(MIN_D); dtab[1] = DB'(MIN_D + 1); dtab[2] = DB'(MAX_D);
`ifdef RGBD_STREAM_DEPTH_GATE_EN
    exp_dtab[0] = '0; exp_dtab[1] = DB'(MIN_D + 1); exp_dtab[2] = '0;
`else
    exp_dtab[0] = DB'(MIN_D); exp_dtab[1] = DB'(MIN_D + 1); exp_dtab[2] = DB'(MAX_D);
`endif
    repeat (3) @(negedge clk);
    check("reset_outputs", {o_rd_req, o_rd_addr, o_frame_start, o_frame_end, o_valid, o_data0, o_depth0, o_busy}, '0);
    i_rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // frame walk, 4x2, latency 1
    start_frame(4, 2, 20'h00100, 1);
    wait_done();
    check("first_valid_latency", 64'(fs_cyc - t0), 64'd3);

    // credit limit, 8x8, latency 12
    start_frame(8, 8, 20'h00400, 12);
    wait_done();
    check("credit_max_outstanding_le_depth", 64'(max_occ <= FIFO_DEPTH), 64'd1);
    check("credit_gaps_present", 64'((fe_cyc - fs_cyc) > 63), 64'd1);

    // ready stall on the 3rd request
    stall_en = 1; stall_exp = 20'h00502;
    start_frame(4, 2, 20'h00500, 2);
    wait_done();
    stall_en = 0;

    // 1x1 frame with a start pulse while busy
    start_frame(1, 1, 20'h00600, 1);
    i_start = 1'b1; r_hsize = 4; r_vsize = 4; r_base_addr = 20'h00700;
    @(negedge clk);
    i_start = 1'b0;
    wait_done();
    repeat (10) @(negedge clk);
    check("extra_start_ignored_busy", {63'd0, o_busy}, 64'd0);

    // address wrap at 2^ADDR_BW
    start_frame(2, 2, 20'hFFFFE, 3);
    wait_done();

    // reset at pixel 5 of 16, then a fresh frame
    p0 = pix_seen;
    start_frame(4, 4, 20'h00200, 1);
    for (i = 0; i < 200 && pix_seen < p0 + 5; i++) @(negedge clk);
    check("reached_pixel5", 64'(pix_seen >= p0 + 5), 64'd1);
    i_rst_n = 1'b0;
    #1;
    check("midframe_reset_outputs", {o_rd_req, o_rd_addr, o_frame_start, o_frame_end, o_valid, o_data0, o_depth0, o_busy}, '0);
    exp_q.delete(); addr_q.delete();
    repeat (3) @(negedge clk);
    i_rst_n = 1'b1;
    repeat (2) @(negedge clk);
    start_frame(4, 4, 20'h00200, 1);
    wait_done();

    // depth gate boundaries
    ovr_en = 1; ovr_base = 20'h00800;
    start_frame(3, 1, 20'h00800, 1);
    wait_done();
    ovr_en = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rgbd_frame_streamer.md
# rgbd_frame_streamer

Raster pixel-stream transmitter feeding the correspondence pipeline. On a start pulse it reads one frame (packed RGB + depth per pixel) from an in-order, variable-latency memory read port and emits it in raster order as the `frame_start` / `frame_end` / `valid` / `data0` / `depth0` stream consumed downstream. Its index counters use the same wrap rules as the consumer's.

## Interface
Parameters:
- `ADDR_BW`, 20, read address width.
- `FIFO_DEPTH`, 8, return-buffer entries; power of two, ≥2.

Ports:
- `i_clk` in 1: clock.
- `i_rst_n` in 1: asynchronous active-low reset.
- `i_start` in 1: one-cycle frame start request.
- `r_hsize` in `H_SIZE_BW`: pixels per line, ≥1.
- `r_vsize` in `V_SIZE_BW`: lines per frame, ≥1.
- `r_base_addr` in `ADDR_BW`: address of pixel (0,0).
- `o_rd_req` out 1: read request.
- `o_rd_addr` out `ADDR_BW`: read address.
- `i_rd_ready` in 1: request accepted this cycle.
- `i_rd_valid` in 1: return data valid; returns arrive in request order.
- `i_rd_data` in `DATA_RGB_BW+DATA_DEPTH_BW`: {rgb, depth}, depth in the LSBs.
- `o_frame_start` out 1: asserted with pixel (0,0).
- `o_frame_end` out 1: asserted with pixel (hsize-1, vsize-1).
- `o_valid` out 1: pixel valid.
- `o_data0` out `DATA_RGB_BW`: RGB.
- `o_depth0` out `DATA_DEPTH_BW`: depth.
- `o_busy` out 1: frame in progress.

## Operation
- FSM states:
  - IDLE: `i_start` latches `r_*` and goes to REQ.
  - REQ: issues requests; after the last request is accepted, goes to DRAIN.
  - DRAIN: waits for the final pixel to pop, then returns to IDLE.
- `i_start` outside IDLE is ignored. `r_*` changes outside IDLE have no effect on the current frame.
- Requests:
  - `o_rd_req` is asserted in REQ only when credit > 0, where credit = `FIFO_DEPTH` − occupancy − in-flight.
  - `o_rd_addr` = base + linear pixel index, modulo 2^`ADDR_BW`.
  - `o_rd_req` and `o_rd_addr` are held stable until `i_rd_ready`.
  - in-flight increments on accept and decrements on `i_rd_valid`. Both events in the same cycle leave it unchanged.
- Return buffer:
  - `i_rd_valid` pushes `i_rd_data`.
  - A push with no credit cannot occur by construction; the bench asserts this.
- Output side (no backpressure):
  - Whenever the buffer is non-empty, one entry pops per cycle and `o_valid`=1 for that pixel.
  - Gaps in `o_valid` are legal.
- Counters:
  - `out_x` / `out_y` advance on each pop.
  - `out_x` wraps to 0 at `r_hsize`−1; `out_y` increments on that wrap and resets to 0 at `r_vsize`−1.
  - `o_frame_start` = pop ∧ x=0 ∧ y=0.
  - `o_frame_end` = pop ∧ x=hsize−1 ∧ y=vsize−1.
  - A 1×1 frame asserts both flags on the same cycle.
- Request-side counters use the same wrap rule.
- `o_busy` = state ≠ IDLE.
- Reset mid-frame:
  - All state, counters, buffer pointers and in-flight return to 0 and the FSM to IDLE.
  - Returns arriving after reset deassertion belong to the aborted frame. The memory side must also be reset.

## Timing
- Reset values: every output 0, including `o_rd_addr` = 0.
- `i_start` at cycle t gives `o_rd_req`=1 at t+1 with `o_rd_addr` = base.
- A push at cycle c gives `o_valid` at c+1 (registered outputs). With 1-cycle memory latency, the first `o_valid` is at t+3.
- Sustained throughput is 1 pixel/cycle when memory latency < `FIFO_DEPTH`.
- Busy timing:
  - `o_busy` rises at t+1.
  - `o_busy` falls the cycle after `o_frame_end`.
  - A new `i_start` is accepted in that same cycle, i.e. the first IDLE cycle.

## Configuration
- `RGBD_STREAM_DEPTH_GATE_EN` defined: `o_depth0` is forced to 0 when the returned depth ≤ `MIN_DEPTH` or ≥ `MAX_DEPTH`. `o_valid`, `o_data0` and the flags are unchanged; the comparison adds no latency.
- Macro undefined: depth passes through unmodified.

## Test plan
- Frame walk: hsize=4, vsize=2, base=0x100, memory latency 1, always ready → addresses 0x100..0x107 in order, 8 consecutive `o_valid`, `frame_start` on pixel 0, `frame_end` on pixel 7, `o_busy` low one cycle later.
- Credit limit: latency 12, `FIFO_DEPTH`=8, 64-pixel frame → in-flight+occupancy never exceeds 8, `o_valid` gaps present, all 64 pixels delivered in order with no drop.
- Ready stall: `i_rd_ready` low for 5 cycles on the 3rd request → `o_rd_addr` held at base+2 for those cycles, no duplicate or skipped address.
- 1×1 frame, plus `i_start` pulsed while busy → a single pixel with `frame_start`=`frame_end`=1; the extra start is ignored.
- Reset mid-frame: `i_rst_n` low at pixel 5 of 16 → all outputs 0. A following start streams a full fresh frame beginning at base.
- Depth gate: with `RGBD_STREAM_DEPTH_GATE_EN`, depth values MIN_DEPTH, MIN_DEPTH+1, MAX_DEPTH → outputs 0, MIN_DEPTH+1, 0. Without the macro → outputs unchanged.
